// File: rtl/display_7s_scan.sv
// rtl/display_7s_scan.sv - 8-digit common-anode 7-segment scan driver with blanking and blink
module display_7s_scan #(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] dis_data,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIGIT_TICKS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [79:0]   snap_q, snap_d;
    logic          load_pend_q, load_pend_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_off_q, blink_off_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          frame_wrap;
    logic [6:0]    base;
    logic [9:0]    field;
    logic          visible;

    always_comb begin
        slot_end     = (cnt_q == CW'(DIGIT_TICKS - 1));
        frame_wrap   = slot_end && (dig_q == 3'd7);
        cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
        dig_d        = slot_end ? dig_q + 3'd1 : dig_q;
        load_pend_d  = 1'b0;
        snap_d       = snap_q;
        fcnt_d       = fcnt_q;
        blink_off_d  = blink_off_q;
        frame_tick_d = frame_wrap;

        // Content only changes at a frame boundary so a frame never shows mixed data.
        if (load_pend_q || frame_wrap) begin
            snap_d = dis_data;
        end

        if (frame_wrap) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d      = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        base    = {4'd0, dig_q} * 7'd10;
        field   = snap_q[base +: 10];
        visible = (cnt_q >= CW'(BLANK_TICKS)) && field[8] && !(field[9] && blink_off_q);

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (visible) begin
            an_d  = ~(8'd1 << dig_q);
            seg_d = ~field[6:0];
            dp_d  = ~field[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            dig_q        <= 3'd0;
            snap_q       <= '0;
            load_pend_q  <= 1'b1;
            fcnt_q       <= '0;
            blink_off_q  <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            snap_q       <= snap_d;
            load_pend_q  <= load_pend_d;
            fcnt_q       <= fcnt_d;
            blink_off_q  <= blink_off_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/display_7s_scan.md
# display_7s_scan

Time-multiplexed scan driver for the 8-digit common-anode 7-segment display. Consumes the 80-bit `dis_data` word produced by the display content mux, snapshots it once per scan frame, and drives active-low anodes, segments and decimal point one digit at a time. Per-digit enable and blink are handled here, along with inter-digit blanking against ghosting. Sits between `display_7s_mux` and the board pins.

## Interface
Parameters:
- `DIGIT_TICKS`, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- `BLANK_TICKS`, 1000: cycles at the start of each slot with all anodes off; must be < `DIGIT_TICKS`.
- `BLINK_FRAMES`, 64: frames per blink half-period.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `dis_data`  in  80  display content; digit i = `dis_data[10*i+9:10*i]`.
  - [6:0] segments a..g, 1 = lit.
  - [7] dp, 1 = lit.
  - [8] enable, 0 = digit dark.
  - [9] blink.
- `an`  out  8  anodes, active-low; `an[0]` = rightmost digit.
- `seg`  out  7  cathodes a..g, active-low; `seg[0]` = a.
- `dp`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse at the start of each frame.

## Operation
- State:
  - `cnt`, 0..`DIGIT_TICKS`-1.
  - `dig`, 0..7.
  - `snap`, 80 bits.
  - `load_pend`, 1 bit.
  - `fcnt`, 0..`BLINK_FRAMES`-1.
  - `blink_off`, 1 bit.
- Reset values:
  - Internal state: `cnt`=0, `dig`=0, `snap`=0, `load_pend`=1, `fcnt`=0, `blink_off`=0.
  - Outputs: `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
- Slot counter:
  - `cnt` increments every cycle.
  - At `cnt`=`DIGIT_TICKS`-1, `cnt` wraps to 0 and `dig` increments mod 8 (7 → 0).
- Frame wrap = the cycle with `cnt`=`DIGIT_TICKS`-1 and `dig`=7. On that cycle:
  - `snap` <= `dis_data`.
  - `frame_tick` <= 1 for the next cycle only.
  - `fcnt` increments.
  - When `fcnt` wraps to 0, `blink_off` toggles.
- `load_pend`:
  - Captures `dis_data` into `snap` on the first cycle after reset release, then clears.
  - `dis_data` changes mid-frame are ignored until the next frame wrap, so there is no tearing.
- Digit visibility: let f = `snap` field for `dig`. The digit is visible iff all of:
  - `cnt` ≥ `BLANK_TICKS`,
  - f[8] = 1,
  - not (f[9] = 1 and `blink_off` = 1).
- Output registers, updated each cycle from current `cnt`/`dig`/`snap`/`blink_off`:
  - Visible: `an` = ~(1 << `dig`), `seg` = ~f[6:0], `dp` = ~f[7].
  - Not visible: `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- At most one `an` bit is ever low. Segments never change while an anode is low.

## Timing
- Output latency: 1 cycle from the state registers.
  - First visible cycle of a slot = slot start + `BLANK_TICKS` + 1.
  - Last visible cycle = the cycle after `cnt`=`DIGIT_TICKS`-1.
- Frame = 8·`DIGIT_TICKS` cycles.
  - `frame_tick` rises on the cycle `dig` becomes 0; period is exactly one frame.
- Blink half-period = `BLINK_FRAMES` frames. `blink_off`=0 (visible) for the first half-period after reset.
- Reset mid-frame:
  - Next cycle: outputs dark, `cnt`/`dig` at 0, blink phase restarted.
  - `snap` reloads one cycle after release.
- `BLANK_TICKS`=0 is legal: no blanking.

## Test plan
Parameters: `DIGIT_TICKS`=10, `BLANK_TICKS`=2, `BLINK_FRAMES`=2.

1. Reset held 5 cycles, then released with `dis_data` = all digits {en=1, seg=7'h3F, dp=0}.
   - During reset and the cycle after: `an`=FF, `seg`=7F, `dp`=1.
   - Slot 0: `an`=FE for cycles 3–10 after release, with `seg`=7'h40.
   - Then `an` steps FD, FB, … 7F every 10 cycles.
2. `frame_tick` cadence.
   - `frame_tick` high exactly 1 cycle every 80 cycles, coincident with `dig` returning to 0.
   - `an` is never more than one bit low (assert every cycle).
3. Tearing: change `dis_data` digit 3 seg from 7'h06 to 7'h5B during slot 5.
   - Digit 3 shows `seg`=~7'h06 for the rest of that frame.
   - Digit 3 shows ~7'h5B in the next frame.
4. Enable/dp: digit 2 en=0, digit 4 dp=1.
   - `an[2]` never low.
   - `dp`=0 only while `an`=EF.
5. Blink: digit 1 blink=1, digit 0 blink=0.
   - `an[1]` lit in frames 0–1, dark in frames 2–3, lit in frames 4–5.
   - `an[0]` lit every frame.
6. Reset asserted at `cnt`=5 of slot 6 for 1 cycle.
   - Next cycle: all outputs dark.
   - Scan restarts at digit 0 with a fresh snapshot and `blink_off`=0.
